// File: rtl/ingress_scheduler.sv
// ingress_scheduler: round-robin sharing of the switch ingress bus among four requesters
module ingress_scheduler #(
   parameter int BURST_MAX = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [63:0] req_data,
   input  logic [63:0] req_addr,
   output logic [3:0]  gnt,
   output logic [15:0] data_in,
   output logic [15:0] addr_in,
   output logic [3:0]  valid_in,
   input  logic [3:0]  rcv_rdy,
   output logic        busy,
   output logic [1:0]  owner,
   output logic        timeout_err
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t      state;
   logic [1:0]  rr_ptr;
   logic [1:0]  winner;
   logic [1:0]  next_ptr;
   logic [3:0]  beat_cnt;
   logic [7:0]  stall_cnt;
   logic        send;
   logic        own_req;
   logic        accept;
   logic        stall;
   logic        last_beat;
   logic        expire;
   assign send      = state == SEND;
   assign own_req   = req[owner];
   assign accept    = send && own_req && rcv_rdy[owner];
   assign stall     = send && own_req && !rcv_rdy[owner];
   assign last_beat = beat_cnt == 4'(BURST_MAX - 1);
   assign expire    = stall_cnt == 8'(TIMEOUT - 1);
   assign next_ptr  = owner + 2'd1;
   assign busy      = send;
   assign timeout_err = stall && expire;
   assign gnt       = accept ? 4'b0001 << owner : 4'b0000;
   assign valid_in  = (send && own_req) ? 4'b0001 << owner : 4'b0000;
   assign data_in   = send ? req_data[{owner, 4'b0000} +: 16] : 16'h0000;
   assign addr_in   = send ? req_addr[{owner, 4'b0000} +: 16] : 16'h0000;
   // first requesting index at or after rr_ptr, wrapping mod 4
   always_comb begin
      winner = rr_ptr;
      for (int k = 3; k >= 0; k--)
         if (req[rr_ptr + 2'(k)]) winner = rr_ptr + 2'(k);
   end
   // grant on the IDLE bubble, count beats and stalls while sending, rotate on burst end, release or timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rr_ptr    <= 2'd0;
         owner     <= 2'd0;
         beat_cnt  <= 4'd0;
         stall_cnt <= 8'd0;
      end else if (!send) begin
         if (|req) begin
            state     <= SEND;
            owner     <= winner;
            beat_cnt  <= 4'd0;
            stall_cnt <= 8'd0;
         end
      end else begin
         if (accept) begin
            beat_cnt  <= beat_cnt + 4'd1;
            stall_cnt <= 8'd0;
         end else if (stall && !expire) begin
            stall_cnt <= stall_cnt + 8'd1;
         end
         if (!own_req || (accept && last_beat) || timeout_err) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
         end
      end
   end
endmodule

// File: tb/tb_ingress_scheduler.sv
// tb_ingress_scheduler: directed stimulus with a per-cycle reference model of the scheduler
module tb_ingress_scheduler;
   localparam int BURST_MAX = 4;
   localparam int TIMEOUT   = 16;
   localparam logic [15:0] BASE [4] = '{16'h0100, 16'h1000, 16'hA000, 16'h3000};
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = 4'h0;
   logic [3:0]  rcv_rdy = 4'h0;
   logic [63:0] req_data;
   logic [63:0] req_addr;
   logic [3:0]  gnt;
   logic [15:0] data_in;
   logic [15:0] addr_in;
   logic [3:0]  valid_in;
   logic        busy;
   logic [1:0]  owner;
   logic        timeout_err;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cnt [4] = '{0, 0, 0, 0};
   logic [3:0]  gnt_s = 4'h0;
   bit          m_send;
   int          m_owner;
   int          m_beats;
   int          m_stalls;
   int          m_ptr;

   ingress_scheduler #(.BURST_MAX(BURST_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_addr(req_addr),
      .gnt(gnt), .data_in(data_in), .addr_in(addr_in), .valid_in(valid_in),
      .rcv_rdy(rcv_rdy), .busy(busy), .owner(owner), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   // each requester presents base + number of words already accepted from it
   for (genvar g = 0; g < 4; g++) begin : src
      assign req_data[16*g +: 16] = 16'(BASE[g] + 16'(cnt[g]));
      assign req_addr[16*g +: 16] = 16'(16'hC000 + 16'h0100 * g + 16'(cnt[g]));
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_send = 0; m_owner = 0; m_beats = 0; m_stalls = 0; m_ptr = 0;
   endtask

   task automatic model_step();
      if (!m_send) begin
         if (req != 4'h0) begin
            for (int k = 3; k >= 0; k--)
               if (req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            m_send = 1; m_beats = 0; m_stalls = 0;
         end
      end else if (!req[m_owner]) begin
         m_send = 0; m_ptr = (m_owner + 1) % 4;
      end else if (rcv_rdy[m_owner]) begin
         m_beats++; m_stalls = 0;
         if (m_beats == BURST_MAX) begin m_send = 0; m_ptr = (m_owner + 1) % 4; end
      end else begin
         m_stalls++;
         if (m_stalls == TIMEOUT) begin m_send = 0; m_ptr = (m_owner + 1) % 4; end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         model_clear();
         for (int i = 0; i < 4; i++) cnt[i] = 0;
      end else begin
         model_step();
         for (int i = 0; i < 4; i++) if (gnt_s[i]) cnt[i]++;
      end
      #1;
   endtask

   task automatic compare();
      logic [3:0]  e_valid;
      logic [3:0]  e_gnt;
      logic        e_to;
      logic [15:0] e_data;
      logic [15:0] e_addr;
      bit          act;
      act     = m_send && req[m_owner];
      e_valid = act ? 4'(1 << m_owner) : 4'h0;
      e_gnt   = (act && rcv_rdy[m_owner]) ? e_valid : 4'h0;
      e_to    = act && !rcv_rdy[m_owner] && (m_stalls == TIMEOUT - 1);
      e_data  = m_send ? 16'(BASE[m_owner] + 16'(cnt[m_owner])) : 16'h0;
      e_addr  = m_send ? 16'(16'hC000 + 16'h0100 * m_owner + 16'(cnt[m_owner])) : 16'h0;
      chk("busy", busy, m_send);
      chk("owner", owner, m_owner);
      chk("valid_in", valid_in, e_valid);
      chk("gnt", gnt, e_gnt);
      chk("timeout_err", timeout_err, e_to);
      chk("data_in", data_in, e_data);
      chk("addr_in", addr_in, e_addr);
   endtask

   task automatic look();
      @(negedge clk);
      compare();
      gnt_s = gnt;
   endtask

   task automatic do_reset();
      tick(); reset = 1'b0; req = 4'h0; rcv_rdy = 4'h0; model_clear(); look();
      tick(); look();
      tick(); reset = 1'b1; look();
   endtask

   initial begin
      int   gcount [4];
      int   order [$];
      bit   pb;
      model_clear();
      // reset then idle
      repeat (3) begin tick(); look(); end
      chk("t1 reset valid", valid_in, 4'h0);
      chk("t1 reset busy", busy, 1'b0);
      tick(); reset = 1'b1; look();
      repeat (10) begin
         tick(); look();
         chk("t1 idle busy", busy, 1'b0);
         chk("t1 idle valid", valid_in, 4'h0);
      end
      // single requester, free switch
      tick(); req = 4'b0100; rcv_rdy = 4'hF; look();
      chk("t2 bubble busy", busy, 1'b0);
      for (int k = 0; k < 4; k++) begin
         tick(); look();
         chk("t2 valid", valid_in, 4'b0100);
         chk("t2 gnt", gnt, 4'b0100);
         chk("t2 data", data_in, 16'hA000 + 16'(k));
      end
      tick(); look();
      chk("t2 rotate bubble", busy, 1'b0);
      chk("t2 rotate gnt", gnt, 4'h0);
      tick(); look();
      chk("t2 second grant data", data_in, 16'hA004);
      chk("t2 second grant gnt", gnt, 4'b0100);
      tick(); req = 4'h0; look();
      chk("t2 release valid", valid_in, 4'h0);
      chk("t2 release busy", busy, 1'b1);
      tick(); look();
      chk("t2 after release", busy, 1'b0);
      // round-robin fairness
      do_reset();
      tick(); req = 4'hF; rcv_rdy = 4'hF; look();
      gcount = '{0, 0, 0, 0};
      pb = 0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) begin tick(); look(); end
         if (busy && !pb) order.push_back(int'(owner));
         pb = busy;
         for (int i = 0; i < 4; i++) gcount[i] += int'(gnt[i]);
      end
      chk("t3 grant count", order.size(), 8);
      foreach (order[i]) chk("t3 grant order", order[i], i % 4);
      for (int i = 0; i < 4; i++) chk("t3 beats per requester", gcount[i], 8);
      // backpressure mid-burst
      do_reset();
      tick(); req = 4'b0010; rcv_rdy = 4'hF; look();
      tick(); look();
      chk("t4 first beat", data_in, 16'h1000);
      chk("t4 first gnt", gnt, 4'b0010);
      for (int s = 0; s < 5; s++) begin
         tick(); if (s == 0) rcv_rdy = 4'b1101; look();
         chk("t4 stall gnt", gnt, 4'h0);
         chk("t4 stall valid", valid_in, 4'b0010);
         chk("t4 stall data", data_in, 16'h1001);
         chk("t4 stall timeout", timeout_err, 1'b0);
      end
      for (int k = 1; k < 4; k++) begin
         tick(); if (k == 1) rcv_rdy = 4'hF; look();
         chk("t4 resume gnt", gnt, 4'b0010);
         chk("t4 resume data", data_in, 16'h1000 + 16'(k));
      end
      tick(); look();
      chk("t4 burst end", busy, 1'b0);
      // watchdog on owner 3
      do_reset();
      tick(); req = 4'b1000; rcv_rdy = 4'h0; look();
      for (int s = 1; s <= 16; s++) begin
         tick(); if (s == 2) req = 4'b1001; look();
         chk("t5 owner", owner, 2'd3);
         chk("t5 timeout pulse", timeout_err, 32'(s == 16));
         chk("t5 no gnt", gnt, 4'h0);
      end
      tick(); look();
      chk("t5 idle after timeout", busy, 1'b0);
      chk("t5 pulse cleared", timeout_err, 1'b0);
      tick(); look();
      chk("t5 next grant busy", busy, 1'b1);
      chk("t5 next grant owner", owner, 2'd0);
      // async reset mid-burst
      do_reset();
      tick(); req = 4'hF; rcv_rdy = 4'hF; look();
      repeat (12) begin tick(); look(); end
      chk("t6 owner2 beat", owner, 2'd2);
      chk("t6 owner2 gnt", gnt, 4'b0100);
      #2 reset = 1'b0;
      model_clear();
      #1;
      chk("t6 async valid", valid_in, 4'h0);
      chk("t6 async gnt", gnt, 4'h0);
      chk("t6 async busy", busy, 1'b0);
      chk("t6 async data", data_in, 16'h0);
      chk("t6 async timeout", timeout_err, 1'b0);
      tick(); look();
      tick(); reset = 1'b1; look();
      chk("t6 released idle", busy, 1'b0);
      tick(); look();
      chk("t6 first owner", owner, 2'd0);
      chk("t6 first busy", busy, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
